// File: rtl/gpio_pinmux_ctrl_if.sv
// -----------------------------------------------------------------------------
// gpio_pinmux_ctrl_if
//
// Register bus between a host and gpio_pinmux_ctrl.
//
//   bus_addr  [2:0]       register address (read and write)
//   wr_en                 write strobe, at most one write per cycle
//   wr_data   [WIDTH-1:0] write data
//   rd_en                 read strobe
//   rd_data   [WIDTH-1:0] registered read data, valid the cycle after rd_en
//
// Modports:
//   master - the host side, drives address/strobes/write data
//   slave  - the register block, returns read data
// -----------------------------------------------------------------------------
interface gpio_pinmux_ctrl_if #(
    parameter int WIDTH = 16
);
    logic [2:0]       bus_addr;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             rd_en;
    logic [WIDTH-1:0] rd_data;

    modport master (
        output bus_addr,
        output wr_en,
        output wr_data,
        output rd_en,
        input  rd_data
    );

    modport slave (
        input  bus_addr,
        input  wr_en,
        input  wr_data,
        input  rd_en,
        output rd_data
    );
endinterface

// File: rtl/gpio_pinmux_ctrl.sv
// -----------------------------------------------------------------------------
// gpio_pinmux_ctrl
//
// GPIO block with per-pin peripheral muxing, input synchronisation, rising
// edge interrupts and an optional FUNC lock.
//
// Parameters:
//   WIDTH        number of pins (1..32)
//   SYNC_STAGES  depth of the pad input synchroniser (2..4)
//
// Ports:
//   clk            single clock, all state updates on the rising edge
//   rst_n          synchronous reset, active low
//   bus            register bus (slave modport of gpio_pinmux_ctrl_if)
//   periph_out     per-pin peripheral output value
//   periph_oe      per-pin peripheral output enable
//   gpio_pins_in   asynchronous pad inputs
//   gpio_pins_out  pad output values
//   gpio_pins_oe   pad output enables
//   periph_in      synchronised pad inputs for the peripherals
//   irq            level interrupt, registered
//
// Register map:
//   0 OUT       rw, bits owned by a peripheral (FUNC=1) hold on write
//   1 DIR       rw, 1 = output, same write protection as OUT
//   2 FUNC      rw, 1 = pin owned by the peripheral
//   3 IRQ_EN    rw
//   4 IRQ_STAT  read, write-1-to-clear; a coincident edge wins over the clear
//   5 IN        ro, synchronised pad values
//   6 LOCK      bit 0, only present when GPIO_PINMUX_LOCK_EN is defined;
//               once set, LOCK and FUNC ignore writes until reset.
//               Without the macro it reads 0 and ignores writes.
//   7 reserved, reads 0, writes ignored
//
// Compile-time option: `define GPIO_PINMUX_LOCK_EN to build in LOCK.
// -----------------------------------------------------------------------------
module gpio_pinmux_ctrl #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    gpio_pinmux_ctrl_if.slave    bus,
    input  logic [WIDTH-1:0]     periph_out,
    input  logic [WIDTH-1:0]     periph_oe,
    input  logic [WIDTH-1:0]     gpio_pins_in,
    output logic [WIDTH-1:0]     gpio_pins_out,
    output logic [WIDTH-1:0]     gpio_pins_oe,
    output logic [WIDTH-1:0]     periph_in,
    output logic                 irq
);

    localparam logic [2:0] ADDR_OUT      = 3'd0;
    localparam logic [2:0] ADDR_DIR      = 3'd1;
    localparam logic [2:0] ADDR_FUNC     = 3'd2;
    localparam logic [2:0] ADDR_IRQ_EN   = 3'd3;
    localparam logic [2:0] ADDR_IRQ_STAT = 3'd4;
    localparam logic [2:0] ADDR_IN       = 3'd5;
    localparam logic [2:0] ADDR_LOCK     = 3'd6;

    localparam int SYNC_BITS = SYNC_STAGES * WIDTH;

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic [WIDTH-1:0]     out_reg,      out_next;
    logic [WIDTH-1:0]     dir_reg,      dir_next;
    logic [WIDTH-1:0]     func_reg,     func_next;
    logic [WIDTH-1:0]     irq_en_reg,   irq_en_next;
    logic [WIDTH-1:0]     irq_stat_reg, irq_stat_next;
    logic [WIDTH-1:0]     rd_data_reg,  rd_data_next;
    logic                 irq_reg,      irq_next;

    // Synchroniser chain, stage 0 in the low WIDTH bits, last stage on top.
    logic [SYNC_BITS-1:0] sync_reg;
    // Previous synchronised sample for the edge detector.
    logic [WIDTH-1:0]     in_prev_reg;
    // Shift register of ones filled after reset. Its top bit means the
    // edge history holds a real pad sample, so the first synchronised
    // sample after reset never counts as an edge.
    logic [SYNC_STAGES:0] fill_reg;

    logic                 lock_active;
`ifdef GPIO_PINMUX_LOCK_EN
    logic                 lock_reg, lock_next;
    assign lock_active = lock_reg;
`else
    assign lock_active = 1'b0;
`endif

    // ---------------------------------------------------------------------
    // Decoded strobes and derived values
    // ---------------------------------------------------------------------
    logic             wr_out, wr_dir, wr_func, wr_irq_en, wr_irq_stat;
    logic [WIDTH-1:0] in_sync;
    logic             edge_ok;
    logic [WIDTH-1:0] stat_set;
    logic [WIDTH-1:0] stat_clr;
    logic [WIDTH-1:0] rd_mux;

    assign wr_out      = bus.wr_en && (bus.bus_addr == ADDR_OUT);
    assign wr_dir      = bus.wr_en && (bus.bus_addr == ADDR_DIR);
    assign wr_func     = bus.wr_en && (bus.bus_addr == ADDR_FUNC) && !lock_active;
    assign wr_irq_en   = bus.wr_en && (bus.bus_addr == ADDR_IRQ_EN);
    assign wr_irq_stat = bus.wr_en && (bus.bus_addr == ADDR_IRQ_STAT);

    assign in_sync  = sync_reg[SYNC_BITS-1 -: WIDTH];
    assign edge_ok  = fill_reg[SYNC_STAGES];
    assign stat_clr = wr_irq_stat ? bus.wr_data : '0;

    // Per-pin mux and edge qualification.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_pin
            assign gpio_pins_out[gi] = func_reg[gi] ? periph_out[gi] : out_reg[gi];
            assign gpio_pins_oe[gi]  = func_reg[gi] ? periph_oe[gi]  : dir_reg[gi];
            // Only GPIO-owned, enabled pins latch an edge into IRQ_STAT.
            assign stat_set[gi] = edge_ok & in_sync[gi] & ~in_prev_reg[gi]
                                & irq_en_reg[gi] & ~func_reg[gi];
        end
    endgenerate

    assign periph_in   = in_sync;
    assign irq         = irq_reg;
    assign bus.rd_data = rd_data_reg;

    // ---------------------------------------------------------------------
    // Read mux (current register values, so a same-cycle write is not seen)
    // ---------------------------------------------------------------------
    always_comb begin
        rd_mux = '0;
        case (bus.bus_addr)
            ADDR_OUT:      rd_mux = out_reg;
            ADDR_DIR:      rd_mux = dir_reg;
            ADDR_FUNC:     rd_mux = func_reg;
            ADDR_IRQ_EN:   rd_mux = irq_en_reg;
            ADDR_IRQ_STAT: rd_mux = irq_stat_reg;
            ADDR_IN:       rd_mux = in_sync;
            ADDR_LOCK:     rd_mux[0] = lock_active;
            default:       rd_mux = '0;
        endcase
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        out_next      = out_reg;
        dir_next      = dir_reg;
        func_next     = func_reg;
        irq_en_next   = irq_en_reg;
        rd_data_next  = rd_data_reg;

        // Peripheral-owned bits keep their stored value on OUT/DIR writes.
        if (wr_out) begin
            out_next = (out_reg & func_reg) | (bus.wr_data & ~func_reg);
        end
        if (wr_dir) begin
            dir_next = (dir_reg & func_reg) | (bus.wr_data & ~func_reg);
        end
        if (wr_func) begin
            func_next = bus.wr_data;
        end
        if (wr_irq_en) begin
            irq_en_next = bus.wr_data;
        end

        // Set is applied after clear so a coincident edge survives W1C.
        irq_stat_next = (irq_stat_reg & ~stat_clr) | stat_set;

        // IRQ_EN masks the output only; IRQ_STAT bits stay set.
        irq_next = |(irq_stat_reg & irq_en_reg);

        if (bus.rd_en) begin
            rd_data_next = rd_mux;
        end
    end

`ifdef GPIO_PINMUX_LOCK_EN
    always_comb begin
        lock_next = lock_reg;
        if (bus.wr_en && (bus.bus_addr == ADDR_LOCK) && bus.wr_data[0]) begin
            lock_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lock_reg <= 1'b0;
        end else begin
            lock_reg <= lock_next;
        end
    end
`endif

    // ---------------------------------------------------------------------
    // Register updates
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_reg      <= '0;
            dir_reg      <= '0;
            func_reg     <= '0;
            irq_en_reg   <= '0;
            irq_stat_reg <= '0;
            rd_data_reg  <= '0;
            irq_reg      <= 1'b0;
            sync_reg     <= '0;
            in_prev_reg  <= '0;
            fill_reg     <= '0;
        end else begin
            out_reg      <= out_next;
            dir_reg      <= dir_next;
            func_reg     <= func_next;
            irq_en_reg   <= irq_en_next;
            irq_stat_reg <= irq_stat_next;
            rd_data_reg  <= rd_data_next;
            irq_reg      <= irq_next;
            sync_reg     <= {sync_reg[SYNC_BITS-WIDTH-1:0], gpio_pins_in};
            in_prev_reg  <= in_sync;
            fill_reg     <= {fill_reg[SYNC_STAGES-1:0], 1'b1};
        end
    end

endmodule

// File: tb/tb_gpio_pinmux_ctrl.sv
// -----------------------------------------------------------------------------
// tb_gpio_pinmux_ctrl
//
// Directed checks with hand-computed values, then randomized traffic. A
// behavioural model tracks the register file and a history of pad samples
// (IN is simply the pad value seen SYNC_STAGES clocks earlier); a negedge
// process compares every output against it each cycle.
// Inputs are driven 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_gpio_pinmux_ctrl;
    localparam int W = 16;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] periph_out, periph_oe, pads;
    logic [W-1:0] gpio_pins_out, gpio_pins_oe, periph_in;
    logic         irq;

    gpio_pinmux_ctrl_if #(.WIDTH(W)) bus ();

    gpio_pinmux_ctrl #(.WIDTH(W), .SYNC_STAGES(S)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .periph_out   (periph_out),
        .periph_oe    (periph_oe),
        .gpio_pins_in (pads),
        .gpio_pins_out(gpio_pins_out),
        .gpio_pins_oe (gpio_pins_oe),
        .periph_in    (periph_in),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit check_en = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // ---------------------------------------------------------------------
    // Behavioural model
    // ---------------------------------------------------------------------
    logic [W-1:0] m_out, m_dir, m_func, m_en, m_stat, m_rd;
    logic         m_irq, m_lock;
    logic [W-1:0] hist [0:7];   // hist[k] = pad value sampled k+1 edges ago
    int           m_n;          // edges since reset (saturating)
    logic [W-1:0] cur_in, prev_in, rise, w1c, wd;

    function automatic logic [W-1:0] model_in();
        return (m_n >= S) ? hist[S-1] : '0;
    endfunction

    function automatic logic [W-1:0] model_read(input logic [2:0] a, input logic [W-1:0] inv);
        case (a)
            3'd0: return m_out;
            3'd1: return m_dir;
            3'd2: return m_func;
            3'd3: return m_en;
            3'd4: return m_stat;
            3'd5: return inv;
            3'd6: return {{(W-1){1'b0}}, m_lock};
            default: return '0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_out = '0; m_dir = '0; m_func = '0; m_en = '0; m_stat = '0;
            m_rd = '0; m_irq = 1'b0; m_lock = 1'b0; m_n = 0;
            for (int k = 0; k < 8; k++) hist[k] = '0;
        end else begin
            wd      = bus.wr_data;
            cur_in  = model_in();
            prev_in = (m_n >= S + 1) ? hist[S] : '0;
            rise    = (m_n >= S + 1) ? (cur_in & ~prev_in) : '0;
            w1c     = (bus.wr_en && bus.bus_addr == 3'd4) ? wd : '0;
            if (bus.rd_en) m_rd = model_read(bus.bus_addr, cur_in);
            m_irq  = |(m_stat & m_en);
            m_stat = (m_stat & ~w1c) | (rise & m_en & ~m_func);
            if (bus.wr_en) begin
                case (bus.bus_addr)
                    3'd0: m_out = (m_out & m_func) | (wd & ~m_func);
                    3'd1: m_dir = (m_dir & m_func) | (wd & ~m_func);
                    3'd2: if (!m_lock) m_func = wd;
                    3'd3: m_en = wd;
`ifdef GPIO_PINMUX_LOCK_EN
                    3'd6: if (wd[0]) m_lock = 1'b1;
`endif
                    default: ;
                endcase
            end
            for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = pads;
            if (m_n < 100) m_n++;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (check_en) begin
            check("rd_data",  32'(bus.rd_data), 32'(m_rd));
            check("pins_out", 32'(gpio_pins_out), 32'((m_func & periph_out) | (~m_func & m_out)));
            check("pins_oe",  32'(gpio_pins_oe),  32'((m_func & periph_oe) | (~m_func & m_dir)));
            check("periph_in", 32'(periph_in), 32'(model_in()));
            check("irq",      32'(irq), 32'(m_irq));
        end
    end

    // ---------------------------------------------------------------------
    // Stimulus helpers (enter and leave 1 unit after a rising edge)
    // ---------------------------------------------------------------------
    task automatic tick();
        @(posedge clk); #1;
        bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [W-1:0] d);
        bus.bus_addr = a; bus.wr_data = d; bus.wr_en = 1'b1; bus.rd_en = 1'b0;
        @(posedge clk); #1;
        bus.wr_en = 1'b0;
    endtask

    task automatic rd_chk(input string nm, input logic [2:0] a, input logic [W-1:0] e);
        bus.bus_addr = a; bus.rd_en = 1'b1; bus.wr_en = 1'b0;
        @(posedge clk); #1;
        bus.rd_en = 1'b0;
        check(nm, 32'(bus.rd_data), 32'(e));
    endtask

`ifdef GPIO_PINMUX_LOCK_EN
    localparam logic [W-1:0] FUNC_AFTER_LOCK = 16'h0000;
    localparam logic [W-1:0] LOCK_READ       = 16'h0001;
`else
    localparam logic [W-1:0] FUNC_AFTER_LOCK = 16'hFFFF;
    localparam logic [W-1:0] LOCK_READ       = 16'h0000;
`endif

    initial begin
        // Reset with both strobes active: reset must dominate.
        rst_n = 1'b0; pads = '0; periph_out = '0; periph_oe = '0;
        bus.bus_addr = 3'd0; bus.wr_data = '1; bus.wr_en = 1'b1; bus.rd_en = 1'b1;
        @(posedge clk); #1;
        check_en = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1; bus.wr_en = 1'b0; bus.rd_en = 1'b0;
        check("rst_rd_data", 32'(bus.rd_data), 32'h0);
        check("rst_oe",      32'(gpio_pins_oe), 32'h0);
        check("rst_out",     32'(gpio_pins_out), 32'h0);
        check("rst_irq",     32'(irq), 32'h0);
        for (int a = 0; a < 8; a++) rd_chk("rst_read", 3'(a), '0);

        // Peripheral owns pin 9; OUT/DIR writes must not touch it.
        wr(3'd2, 16'h0200);
        periph_out = 16'h0200; periph_oe = 16'h0200;
        wr(3'd0, 16'h0000);
        wr(3'd1, 16'hFFFF);
        check("pin9_out", 32'(gpio_pins_out[9]), 32'h1);
        check("oe_all",   32'(gpio_pins_oe), 32'hFFFF);
        rd_chk("out_rd", 3'd0, 16'h0000);
        rd_chk("dir_rd", 3'd1, 16'hFDFF);

        // Peripheral owns pins 7:4.
        periph_out = 16'h00A0;
        wr(3'd2, 16'h00F0);
        wr(3'd0, 16'hFFFF);
        rd_chk("out_prot", 3'd0, 16'hFF0F);
        check("pins_mix", 32'(gpio_pins_out), 32'hFFAF);
        check("oe_mix",   32'(gpio_pins_oe),  32'hFD0F);

        // Edge interrupt latency on pad 0.
        wr(3'd2, 16'h0000);
        wr(3'd3, 16'h0001);
        repeat (3) tick();
        pads = 16'h0001;
        tick(); tick(); tick();
        check("irq_lat_low", 32'(irq), 32'h0);
        rd_chk("stat_set", 3'd4, 16'h0001);
        check("irq_lat_high", 32'(irq), 32'h1);

        // W1C coincident with a new edge: the set wins.
        pads = 16'h0000; repeat (4) tick();
        pads = 16'h0001; tick(); tick();
        wr(3'd4, 16'h0001);
        rd_chk("w1c_vs_edge", 3'd4, 16'h0001);
        wr(3'd4, 16'h0001);
        rd_chk("w1c_alone", 3'd4, 16'h0000);
        check("irq_cleared", 32'(irq), 32'h0);

        // Disabling IRQ_EN masks irq but keeps the status bit.
        pads = 16'h0000; repeat (4) tick();
        pads = 16'h0001; repeat (3) tick();
        wr(3'd3, 16'h0000);
        tick();
        check("irq_masked", 32'(irq), 32'h0);
        rd_chk("stat_kept", 3'd4, 16'h0001);
        wr(3'd4, 16'hFFFF);

        // Same-cycle read and write returns the old value.
        wr(3'd3, 16'hFFFF);
        bus.bus_addr = 3'd3; bus.wr_data = 16'h1234; bus.wr_en = 1'b1; bus.rd_en = 1'b1;
        tick();
        check("rd_wr_same", 32'(bus.rd_data), 32'hFFFF);
        rd_chk("rd_after_wr", 3'd3, 16'h1234);

        // LOCK behaviour.
        wr(3'd6, 16'h0001);
        wr(3'd2, 16'hFFFF);
        rd_chk("func_lock", 3'd2, FUNC_AFTER_LOCK);
        rd_chk("lock_rd",   3'd6, LOCK_READ);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        rd_chk("func_rst", 3'd2, 16'h0000);
        rd_chk("lock_rst", 3'd6, 16'h0000);

        // Reset while irq is high and an edge is in the synchroniser.
        wr(3'd3, 16'h0002);
        pads = 16'h0003; repeat (4) tick();
        check("irq_pre_rst", 32'(irq), 32'h1);
        pads = 16'h0007; tick();
        rst_n = 1'b0; tick();
        check("irq_rst", 32'(irq), 32'h0);
        rst_n = 1'b1;
        wr(3'd3, 16'hFFFF);
        repeat (8) tick();
        rd_chk("stat_after_rst", 3'd4, 16'h0000);
        check("irq_after_rst", 32'(irq), 32'h0);

        // Randomized traffic.
        for (int c = 0; c < 1500; c++) begin
            rst_n        = ($urandom_range(0, 299) != 0);
            bus.wr_en    = ($urandom_range(0, 2) == 0);
            bus.rd_en    = ($urandom_range(0, 2) == 0);
            bus.bus_addr = 3'($urandom_range(0, 7));
            bus.wr_data  = W'($urandom);
            if (bus.bus_addr == 3'd2 && $urandom_range(0, 1) == 0)
                bus.wr_data = bus.wr_data & W'($urandom);
            pads       = pads ^ (W'($urandom) & W'($urandom) & W'($urandom));
            periph_out = W'($urandom);
            periph_oe  = W'($urandom);
            @(posedge clk); #1;
        end
        rst_n = 1'b1; bus.wr_en = 1'b0; bus.rd_en = 1'b0;
        tick();
        @(negedge clk); #1;
        check_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
